// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter and sequencer shared by the
// instruction-fetch path and the load/store path of the multicycle core.
// One transaction is outstanding at a time. Each transaction takes
// MEM_LATENCY+2 cycles from grant to response pulse.
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   -> round-robin arbitration on a tie. The pointer
//                               starts at "last = fetch", so the first tie
//                               after reset goes to data.
//   MEM_ARB_RR_EN  undefined -> fixed priority, data beats fetch.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_LATENCY = 2    // legal range >= 1
) (
  input  logic                  clk,
  input  logic                  reset,
  // fetch port
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  // load/store port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  // memory side
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // The latency counter must hold MEM_LATENCY-1. It is reloaded only in ISSUE.
  localparam int              CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [CNT_W-1:0]        cnt_r;
  logic                    owner_r;     // which port owns the transaction in flight
  logic                    we_r;        // in-flight transaction is a store
  logic                    mem_en_r;
  logic                    mem_we_r;
  logic [ADDR_WIDTH-1:0]   mem_addr_r;
  logic [DATA_WIDTH-1:0]   mem_wdata_r;
  logic                    if_rvalid_r;
  logic                    d_rvalid_r;
  logic [DATA_WIDTH-1:0]   if_rdata_r;
  logic [DATA_WIDTH-1:0]   d_rdata_r;

  logic                    arb_point_s;
  logic                    if_gnt_s;
  logic                    d_gnt_s;
  logic                    any_gnt_s;
  logic                    wait_done_s;

`ifdef MEM_ARB_RR_EN
  logic                    last_data_r; // 1 = data was granted most recently
`endif

  assign arb_point_s = (state_r == IDLE) || (state_r == DONE);
  assign wait_done_s = (state_r == WAIT) && (cnt_r == CNT_ZERO);
  assign any_gnt_s   = if_gnt_s | d_gnt_s;

  // Combinational grant. Grants happen only at arbitration points and never
  // while reset is asserted, because nothing would be latched in that cycle.
  always_comb begin
    if_gnt_s = 1'b0;
    d_gnt_s  = 1'b0;
    if (arb_point_s && !reset) begin
`ifdef MEM_ARB_RR_EN
      if (d_req && if_req) begin
        if (last_data_r) begin
          if_gnt_s = 1'b1;
        end else begin
          d_gnt_s  = 1'b1;
        end
      end else begin
        d_gnt_s  = d_req;
        if_gnt_s = if_req;
      end
`else
      if (d_req) begin
        d_gnt_s = 1'b1;
      end else if (if_req) begin
        if_gnt_s = 1'b1;
      end else begin
        if_gnt_s = 1'b0;
        d_gnt_s  = 1'b0;
      end
`endif
    end else begin
      if_gnt_s = 1'b0;
      d_gnt_s  = 1'b0;
    end
  end

  // Next-state logic for the sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (any_gnt_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: state_nxt_s = WAIT;
      WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register. Reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latency counter. It is loaded in ISSUE and counts down in WAIT. It stops at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= CNT_ZERO;
    end else if (state_r == ISSUE) begin
      cnt_r <= CNT_LOAD;
    end else if ((state_r == WAIT) && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Latch the owner and request details at grant. mem_en/mem_we are strobed
  // for exactly the ISSUE cycle that follows the grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r     <= OWN_FETCH;
      we_r        <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      mem_en_r <= any_gnt_s;
      mem_we_r <= d_gnt_s & d_we;
      if (d_gnt_s) begin
        owner_r     <= OWN_DATA;
        we_r        <= d_we;
        mem_addr_r  <= d_addr;
        mem_wdata_r <= d_wdata;
      end else if (if_gnt_s) begin
        owner_r     <= OWN_FETCH;
        we_r        <= 1'b0;
        mem_addr_r  <= if_addr;
        mem_wdata_r <= mem_wdata_r;
      end else begin
        owner_r     <= owner_r;
        we_r        <= we_r;
        mem_addr_r  <= mem_addr_r;
        mem_wdata_r <= mem_wdata_r;
      end
    end
  end

  // Capture read data on the last WAIT cycle. The response pulse lands in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      if_rdata_r  <= {DATA_WIDTH{1'b0}};
      d_rdata_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      if_rvalid_r <= wait_done_s && (owner_r == OWN_FETCH);
      d_rvalid_r  <= wait_done_s && (owner_r == OWN_DATA);
      if (wait_done_s && (owner_r == OWN_FETCH)) begin
        if_rdata_r <= mem_rdata;
      end else begin
        if_rdata_r <= if_rdata_r;
      end
      if (wait_done_s && (owner_r == OWN_DATA) && !we_r) begin
        d_rdata_r <= mem_rdata;
      end else begin
        d_rdata_r <= d_rdata_r;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  // Round-robin pointer. It records which port received the most recent grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_data_r <= 1'b0;
    end else if (d_gnt_s) begin
      last_data_r <= 1'b1;
    end else if (if_gnt_s) begin
      last_data_r <= 1'b0;
    end else begin
      last_data_r <= last_data_r;
    end
  end
`endif

  assign if_gnt    = if_gnt_s;
  assign d_gnt     = d_gnt_s;
  assign if_rvalid = if_rvalid_r;
  assign d_rvalid  = d_rvalid_r;
  assign if_rdata  = if_rdata_r;
  assign d_rdata   = d_rdata_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule
